// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: one table of saturating counters indexed by
// PC XOR global history, with speculative history shift and mispredict repair.
module gshare_predictor #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INDEX_WIDTH = 10,
   parameter int HIST_WIDTH  = 8,
   parameter int CNT_WIDTH   = 2,
   parameter int CNT_INIT    = 2**(CNT_WIDTH-1)-1
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  pred_valid,
   input  logic [ADDR_WIDTH-1:0] pred_pc,
   output logic                  pred_taken,
   output logic [HIST_WIDTH-1:0] pred_hist,
   input  logic                  upd_valid,
   input  logic [ADDR_WIDTH-1:0] upd_pc,
   input  logic [HIST_WIDTH-1:0] upd_hist,
   input  logic                  upd_taken,
   input  logic                  upd_mispredict,
   output logic [HIST_WIDTH-1:0] ghr_out
);

   localparam int ENTRIES = 1 << INDEX_WIDTH;
   localparam logic [CNT_WIDTH-1:0] CNT_RESET = CNT_WIDTH'(CNT_INIT);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

   logic [CNT_WIDTH-1:0]   cnt_q [ENTRIES];
   logic [HIST_WIDTH-1:0]  ghr_q, ghr_d;
   logic [CNT_WIDTH-1:0]   updCnt, updCnt_d;
   logic [INDEX_WIDTH-1:0] predIdx, updIdx;
   logic                   repair;
   logic                   unusedPcBits;

   function automatic logic [INDEX_WIDTH-1:0] hashIdx(input logic [ADDR_WIDTH-1:0] pc,
                                                      input logic [HIST_WIDTH-1:0] h);
      logic [INDEX_WIDTH-1:0] hx;
      hx = '0;
      hx[HIST_WIDTH-1:0] = h;
      return pc[INDEX_WIDTH+1:2] ^ hx;
   endfunction

   assign unusedPcBits = ^{pred_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], pred_pc[1:0],
                           upd_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], upd_pc[1:0]};

   assign predIdx    = hashIdx(pred_pc, ghr_q);
   assign updIdx     = hashIdx(upd_pc, upd_hist);
   assign pred_taken = cnt_q[predIdx][CNT_WIDTH-1];
   assign pred_hist  = ghr_q;
   assign ghr_out    = ghr_q;
   assign repair     = upd_valid & upd_mispredict;
   assign updCnt     = cnt_q[updIdx];

   // Repair wins over the speculative shift; the shifted-in bit is the live prediction.
   always_comb begin
      ghr_d = ghr_q;
      if (rdy_in) begin
         if (repair)
            ghr_d = {upd_hist[HIST_WIDTH-2:0], upd_taken};
         else if (pred_valid)
            ghr_d = {ghr_q[HIST_WIDTH-2:0], pred_taken};
      end
   end

   always_comb begin
      updCnt_d = updCnt;
      if (upd_taken) begin
         if (updCnt != CNT_MAX)
            updCnt_d = updCnt + 1'b1;
      end else begin
         if (updCnt != '0)
            updCnt_d = updCnt - 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   // Prediction reads the table combinationally, so a same-cycle update is seen next cycle.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < ENTRIES; i++)
            cnt_q[i] <= CNT_RESET;
      end else if (rdy_in && upd_valid) begin
         cnt_q[updIdx] <= updCnt_d;
      end
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// Table-driven self-checking bench for gshare_predictor with an expected-value queue.
module tb_gshare_predictor;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, pred_valid, upd_valid, upd_taken, upd_mispredict;
   logic [31:0] pred_pc, upd_pc;
   logic [7:0]  upd_hist, pred_hist, ghr_out;
   logic        pred_taken;

   typedef struct {
      logic        rst, rdy, pv;
      logic [31:0] ppc;
      logic        uv;
      logic [31:0] upc;
      logic [7:0]  uh;
      logic        ut, um;
      logic        expTaken;
      logic [7:0]  expHist, expGhr;
   } vec_t;

   typedef struct {
      int         id;
      logic       taken;
      logic [7:0] hist, ghr;
   } exp_t;

   vec_t vecs[$];
   exp_t scoreboard[$];
   int   vectorCount = 0;
   int   missCount   = 0;

   gshare_predictor dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
      .pred_hist(pred_hist), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_hist(upd_hist), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
      .ghr_out(ghr_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic vec_t mk(input logic rst, rdy, pv, input logic [31:0] ppc,
                               input logic uv, input logic [31:0] upc, input logic [7:0] uh,
                               input logic ut, um, eT, input logic [7:0] eH, eG);
      vec_t v;
      v.rst = rst; v.rdy = rdy; v.pv = pv; v.ppc = ppc;
      v.uv = uv; v.upc = upc; v.uh = uh; v.ut = ut; v.um = um;
      v.expTaken = eT; v.expHist = eH; v.expGhr = eG;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v, input int id);
      exp_t e;
      rst_in = v.rst; rdy_in = v.rdy; pred_valid = v.pv; pred_pc = v.ppc;
      upd_valid = v.uv; upd_pc = v.upc; upd_hist = v.uh;
      upd_taken = v.ut; upd_mispredict = v.um;
      e.id = id; e.taken = v.expTaken; e.hist = v.expHist; e.ghr = v.expGhr;
      scoreboard.push_back(e);
      vectorCount++;
   endtask

   task automatic checkOutput();
      exp_t e;
      if (scoreboard.size() == 0) begin
         $display("[TB] FAIL scoreboard_empty actual=0 entries required=1");
         missCount++;
         return;
      end
      e = scoreboard.pop_front();
      if (pred_taken !== e.taken) begin
         $display("[TB] FAIL vec%0d pred_taken actual=%b required=%b", e.id, pred_taken, e.taken);
         missCount++;
      end
      if (pred_hist !== e.hist) begin
         $display("[TB] FAIL vec%0d pred_hist actual=%h required=%h", e.id, pred_hist, e.hist);
         missCount++;
      end
      if (ghr_out !== e.ghr) begin
         $display("[TB] FAIL vec%0d ghr_out actual=%h required=%h", e.id, ghr_out, e.ghr);
         missCount++;
      end
   endtask

   // One cycle: drive just after the edge, compare mid-cycle, then let the edge act.
   task automatic runVector(input vec_t v, input int id);
      applyStimulus(v, id);
      #2;
      checkOutput();
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      // rst rdy pv ppc          uv upc          uh     ut    um    eT    eH     eG
      vecs.push_back(mk(0,1,0,32'h100, 0,32'h000,8'h00,1'b0,1'b0, 1'b0,8'h00,8'h00)); // reset values
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b1,1'b0, 1'b0,8'h00,8'h00)); // cnt 1
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b1,1'b0, 1'b1,8'h00,8'h00)); // cnt 2
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b1,1'b0, 1'b1,8'h00,8'h00)); // cnt 3
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b1,1'b0, 1'b1,8'h00,8'h00)); // sat 3
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b1,1'b0, 1'b1,8'h00,8'h00)); // sat 3
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b0,1'b0, 1'b1,8'h00,8'h00)); // cnt 3
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b0,1'b0, 1'b1,8'h00,8'h00)); // cnt 2
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b0,1'b0, 1'b0,8'h00,8'h00)); // cnt 1
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b0,1'b0, 1'b0,8'h00,8'h00)); // cnt 0
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b0,1'b0, 1'b0,8'h00,8'h00)); // cnt 0
      vecs.push_back(mk(0,1,0,32'h100, 0,32'h000,8'h00,1'b0,1'b0, 1'b0,8'h00,8'h00)); // no wrap
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b1,1'b0, 1'b0,8'h00,8'h00));
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b1,1'b0, 1'b0,8'h00,8'h00));
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b1,1'b0, 1'b1,8'h00,8'h00));
      vecs.push_back(mk(0,1,1,32'h100, 0,32'h000,8'h00,1'b0,1'b0, 1'b1,8'h00,8'h00)); // speculative
      vecs.push_back(mk(0,1,1,32'h100, 0,32'h000,8'h00,1'b0,1'b0, 1'b0,8'h01,8'h01));
      vecs.push_back(mk(0,1,1,32'h100, 0,32'h000,8'h00,1'b0,1'b0, 1'b0,8'h02,8'h02));
      vecs.push_back(mk(0,1,0,32'h100, 0,32'h000,8'h00,1'b0,1'b0, 1'b0,8'h04,8'h04));
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h800,8'h01,1'b0,1'b1, 1'b0,8'h04,8'h04)); // ghr -> 02
      vecs.push_back(mk(0,1,1,32'h100, 1,32'h800,8'h5A,1'b1,1'b1, 1'b0,8'h02,8'h02)); // repair wins
      vecs.push_back(mk(0,1,0,32'h100, 0,32'h000,8'h00,1'b0,1'b0, 1'b0,8'hB5,8'hB5));
      for (int i = 0; i < 5; i++)                                                      // stall
         vecs.push_back(mk(0,0,1,32'h3D4, 1,32'h100,8'h00,1'b0,1'b1, 1'b1,8'hB5,8'hB5));
      vecs.push_back(mk(0,1,1,32'h3D4, 0,32'h000,8'h00,1'b0,1'b0, 1'b1,8'hB5,8'hB5));
      vecs.push_back(mk(0,1,0,32'h3D4, 0,32'h000,8'h00,1'b0,1'b0, 1'b0,8'h6B,8'h6B));
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h800,8'h00,1'b0,1'b1, 1'b0,8'h6B,8'h6B)); // ghr -> 00
      vecs.push_back(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b0,1'b0, 1'b1,8'h00,8'h00)); // read-before-write
      vecs.push_back(mk(1,1,1,32'h100, 1,32'h100,8'h00,1'b0,1'b0, 1'b1,8'h00,8'h00)); // reset mid-op
      vecs.push_back(mk(0,1,0,32'h100, 0,32'h000,8'h00,1'b0,1'b0, 1'b0,8'h00,8'h00));

      rst_in = 1'b1; rdy_in = 1'b1; pred_valid = 1'b0; pred_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_hist = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
      @(posedge clk_in);
      #1;

      foreach (vecs[i])
         runVector(vecs[i], i);

      // Reset must override a low rdy_in: build up history and a counter, then reset while stalled.
      runVector(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b1,1'b1, 1'b0,8'h00,8'h00), 100);
      runVector(mk(1,0,1,32'h100, 1,32'h100,8'h00,1'b1,1'b1, 1'b0,8'h01,8'h01), 101);
      runVector(mk(0,1,0,32'h100, 0,32'h000,8'h00,1'b0,1'b0, 1'b0,8'h00,8'h00), 102);
      runVector(mk(0,1,0,32'h100, 1,32'h100,8'h00,1'b1,1'b0, 1'b0,8'h00,8'h00), 103);
      runVector(mk(0,1,0,32'h100, 0,32'h000,8'h00,1'b0,1'b0, 1'b1,8'h00,8'h00), 104);

      if (scoreboard.size() != 0) begin
         $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", scoreboard.size());
         missCount++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised global-history (gshare) conditional-branch direction predictor. It replaces the fixed 1024-entry, 4-way local-selection predictor with a single table of N-bit saturating counters indexed by PC XOR global history register (GHR). It also supports speculative history update at predict time and history repair on mispredict. It sits between the instruction fetch unit (predict side) and the branch-resolution path in the ROB/ALU (update side).

## Interface
- ADDR_WIDTH, 32, instruction address width.
- INDEX_WIDTH, 10, log2 of pattern-table entries; PC bits [INDEX_WIDTH+1:2] form the base index.
- HIST_WIDTH, 8, GHR length; legal range 2..INDEX_WIDTH.
- CNT_WIDTH, 2, saturating counter width; legal range ≥ 1.
- CNT_INIT, 2**(CNT_WIDTH-1)-1, reset value of every counter (weakly not-taken).

- clk_in  input  1  system clock; all state changes on rising edge.
- rst_in  input  1  reset; one clock, synchronous and active-high.
- rdy_in  input  1  ready; when low, no state changes (predict and update ignored).
- pred_valid  input  1  fetch is predicting a branch this cycle.
- pred_pc  input  ADDR_WIDTH  PC of the branch being predicted.
- pred_taken  output  1  predicted direction (1 = taken).
- pred_hist  output  HIST_WIDTH  GHR value used for this prediction; carried with the branch to resolution.
- upd_valid  input  1  a conditional branch resolved this cycle.
- upd_pc  input  ADDR_WIDTH  PC of the resolved branch.
- upd_hist  input  HIST_WIDTH  pred_hist captured when that branch was predicted.
- upd_taken  input  1  actual direction.
- upd_mispredict  input  1  resolved direction differs from prediction; qualified by upd_valid.
- ghr_out  output  HIST_WIDTH  current GHR, for debug/trace.

## Operation
- Index function: idx(pc, h) = pc[INDEX_WIDTH+1:2] XOR zero-extend(h) to INDEX_WIDTH bits.
- Predict (combinational): pred_hist = GHR; pred_taken = MSB of counter[idx(pred_pc, GHR)]. Both outputs are driven regardless of pred_valid.
- Speculative history: on an edge with rdy_in & pred_valid & ~(upd_valid & upd_mispredict), GHR <= {GHR[HIST_WIDTH-2:0], pred_taken}.
- Repair: on an edge with rdy_in & upd_valid & upd_mispredict, GHR <= {upd_hist[HIST_WIDTH-2:0], upd_taken}. Repair has priority over the same-cycle speculative shift, and that prediction's shift is discarded.
- Counter training: on an edge with rdy_in & upd_valid, counter[idx(upd_pc, upd_hist)] increments if upd_taken, else decrements. It saturates at 2**CNT_WIDTH-1 and at 0, with no wrap-around. Training occurs whether or not the branch mispredicted.
- Same-cycle predict and update to the same index: pred_taken reflects the pre-update counter value (read-before-write). The new value is visible from the next cycle.
- Reset: all counters <= CNT_INIT; GHR <= 0. Reset overrides rdy_in and all requests. Reset mid-operation discards all training and history.

## Timing
- Predict latency 0 cycles: outputs are valid in the same cycle as pred_pc, from current registered state.
- GHR and counter changes become visible in the cycle after the triggering edge.
- After reset: GHR = 0, ghr_out = 0, pred_hist = 0, pred_taken = MSB(CNT_INIT) = 0 for any pred_pc.
- rdy_in low: GHR and counters hold; outputs still track pred_pc combinationally.
- At most one predict and one update per cycle. No backpressure and no handshake: both request sides are fire-and-forget.

## Test plan
- Reset values (defaults): after rst_in pulse, pred_pc=0x100 -> pred_taken=0, pred_hist=0x00, ghr_out=0x00.
- Saturation: four updates upd_pc=0x100, upd_hist=0x00, upd_taken=1 -> counter[0x040]=3, pred_pc=0x100 with GHR=0 -> pred_taken=1. One further taken update keeps it at 3. Then one not-taken -> counter 2, still taken. Second not-taken -> counter 1, pred_taken=0. Three more not-taken -> counter 0, no wrap.
- Speculative history: after training index 0x040 to 3 from reset, pred_valid with pred_pc=0x100 for 3 consecutive cycles -> pred_hist 0x00, 0x01, 0x02 and pred_taken 1, 0, 0. ghr_out ends at 0x04.
- Repair priority: GHR=0x02. Same cycle: pred_valid=1 and upd_valid=upd_mispredict=1 with upd_hist=0x5A, upd_taken=1 -> next cycle ghr_out=0xB5, not 0x04/0x05.
- Stall: rdy_in=0 with pred_valid, upd_valid and upd_mispredict all asserted for 5 cycles -> ghr_out and all counters unchanged. Raising rdy_in resumes normal behaviour.
- Reset mid-operation and read-before-write: train counter[0x040]=3, then in one cycle update it not-taken while predicting pred_pc=0x100 at GHR=0 -> pred_taken=1 that cycle, 1 (counter 2) the next. Then assert rst_in for 1 cycle with updates pending -> counter[0x040]=1, GHR=0, pred_taken=0.
